axi_txn_issuer: RTL and testbench
=================================

AXI_TXN_ISSUER -- requirements
Module: axi_txn_issuer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- VLSU_ADDR_BITS, 32, nibble address width.
- AXI4_ADDR_BITS, 32, AXI byte address width.
- REQ_ID_BITS, 8, request id width.
- TXN_BITS, 8, txnCnt/txnNum width.
- MAX_OUTSTD, 8, maximum in-flight AXI transactions.
REQ-002 clk_i  input  1  clock.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Meta input from the fragmenter:
- meta_valid_i  input  1  per-transaction meta valid.
- meta_ready_o  output  1  meta consumed.
- meta_req_id_i  input  REQ_ID_BITS  request id.
- meta_is_load_i  input  1  load (AR) / store (AW).
- meta_seg_base_i  input  VLSU_ADDR_BITS  segment base nibble address.
- meta_txn_cnt_i  input  TXN_BITS  transaction index within segment.
- meta_txn_num_i  input  TXN_BITS  last transaction index.
- meta_ltn_i  input  6  last-transaction end nibble, 1..32.
- meta_final_i  input  1  final transaction of request.
REQ-005 AXI address channel:
- ax_valid_o  output  1  address valid.
- ax_ready_i  input  1  address accepted.
- ax_addr_o  output  AXI4_ADDR_BITS  16-byte-aligned byte address.
- ax_is_load_o  output  1  selects AR (1) or AW (0).
- ax_id_o  output  REQ_ID_BITS  AXI id.
- ax_len, ax_size and ax_burst are constant 0, 4, INCR and live in the package, not on ports.
REQ-006 Transaction-info output to the datapath:
- info_valid_o  output  1  info valid.
- info_ready_i  input  1  info accepted.
- info_start_nb_o  output  5  first valid nibble.
- info_end_nb_o  output  6  exclusive end nibble.
- info_is_load_o  output  1  load/store.
- info_last_o  output  1  final transaction of request.
REQ-007 Response and status:
- resp_done_i  input  1  one AXI response (R last or B) completed.
- outstd_cnt_o  output  $clog2(MAX_OUTSTD+1)  in-flight count.
- idle_o  output  1  no pending slot and outstd_cnt_o==0.

Function
REQ-008 The block SHALL hold one issue slot containing one address record and one info record, each with its own sent flag.
REQ-009 Slot states SHALL be S_EMPTY, S_PEND (both records unsent), S_AX_ONLY (info sent, address pending) and S_INFO_ONLY (address sent, info pending).
REQ-010 Meta SHALL be accepted when meta_valid_i && meta_ready_o; the slot SHALL enter S_PEND on the next cycle (one-cycle latency).
REQ-011 meta_ready_o SHALL equal (slot frees this cycle) && (outstd_cnt_o + pending-unissued < MAX_OUTSTD).
- The slot frees this cycle when it is S_EMPTY, or when every unsent handshake completes this cycle.
REQ-012 ax_valid_o SHALL be high in S_PEND and S_AX_ONLY; info_valid_o SHALL be high in S_PEND and S_INFO_ONLY.
REQ-013 Both valids SHALL stay asserted with stable payload until their handshake; no valid SHALL depend combinationally on its ready.
REQ-014 Simultaneous ax and info handshakes in S_PEND SHALL return the slot to S_EMPTY, or to S_PEND if new meta is accepted in the same cycle.
REQ-015 Address computation:
- aligned = meta_seg_base_i with bits[4:0] cleared.
- nib = aligned + meta_txn_cnt_i*32.
- ax_addr_o = nib>>1, truncated to AXI4_ADDR_BITS, with bits[3:0] = 0.
REQ-016 info_start_nb_o SHALL be meta_seg_base_i[4:0] if meta_txn_cnt_i==0, else 0.
REQ-017 info_end_nb_o SHALL be meta_ltn_i if meta_txn_cnt_i==meta_txn_num_i, else 32.
REQ-018 ax_id_o SHALL be meta_req_id_i.
REQ-019 outstd_cnt_o SHALL increment on ax handshake and decrement on resp_done_i; both in the same cycle SHALL leave it unchanged.
REQ-020 resp_done_i with outstd_cnt_o==0 SHALL be ignored; the counter SHALL never exceed MAX_OUTSTD.

Reset
REQ-021 On rst_ni low, the slot SHALL be S_EMPTY and ax_valid_o, info_valid_o and outstd_cnt_o SHALL be 0.
REQ-022 On rst_ni low, meta_ready_o SHALL be 1 and idle_o SHALL be 1.
REQ-023 Reset mid-operation SHALL drop any pending slot without issuing it.

Configuration
REQ-024 With AXI_TXN_ISSUER_PERF_CNT_EN defined, outputs perf_txn_o[31:0] and perf_stall_o[31:0] SHALL exist.
- perf_txn_o counts ax handshakes.
- perf_stall_o counts cycles with meta_valid_i && !meta_ready_o.
- Both counters wrap and reset to 0.
REQ-025 Without AXI_TXN_ISSUER_PERF_CNT_EN, both ports SHALL exist tied to 0, with no counter flops.

Structure
REQ-026 The following SHALL go in the shared VLSU package:
- constants SLEN=128, NB_PER_TXN=32, AX_SIZE=4;
- txn_info_t {start_nb, end_nb, is_load, last};
- slot state enum.
REQ-027 The offset/end/address arithmetic SHALL be a combinational sub-module txn_addr_calc, instantiated once.

Verification
REQ-028 Seg base 0x105, txnCnt 0, txnNum 1, ltN 5, load -> ax_addr 0x80, start 5, end 32, ax_is_load=1.
REQ-029 Same segment, txnCnt 1 -> ax_addr 0x90, start 0, end 5; meta_final_i=1 -> info_last_o=1.
REQ-030 ax_ready_i=1, info_ready_i held 0 for 3 cycles -> slot S_INFO_ONLY, meta_ready_o=0, outstd_cnt_o=1, ax_valid_o=0.
REQ-031 MAX_OUTSTD=2, issue 2 txns with no responses -> meta_ready_o=0; one resp_done_i -> meta_ready_o=1 the same cycle.
REQ-032 ax handshake coincident with resp_done_i at count 3 -> count stays 3; resp_done_i at count 0 -> count stays 0.
REQ-033 Assert rst_ni low while in S_PEND -> next cycle both valids 0, idle_o=1, no handshake observed.

Source files
------------

// File: rtl/axi_txn_issuer_pkg.sv
// Shared VLSU package for the AXI transaction issuer: fixed AXI burst shape,
// per-transaction info record and issue-slot state encoding.
package axi_txn_issuer_pkg;

  localparam int unsigned SLEN       = 128;
  localparam int unsigned NB_PER_TXN = 32;

  // Every issued transaction is a single 16-byte beat.
  localparam logic [2:0] AX_SIZE = 3'd4;
  localparam logic [7:0] AX_LEN  = 8'd0;

  typedef enum logic [1:0] {
    AX_BURST_FIXED = 2'b00,
    AX_BURST_INCR  = 2'b01,
    AX_BURST_WRAP  = 2'b10
  } ax_burst_e;

  localparam ax_burst_e AX_BURST = AX_BURST_INCR;

  typedef struct packed {
    logic [4:0] start_nb;
    logic [5:0] end_nb;
    logic       is_load;
    logic       last;
  } txn_info_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PEND,
    S_AX_ONLY,
    S_INFO_ONLY
  } slot_state_e;

  function automatic logic [5:0] txn_end_nb(input logic is_last_txn, input logic [5:0] ltn);
    return is_last_txn ? ltn : 6'(NB_PER_TXN);
  endfunction

endpackage

// File: rtl/axi_txn_issuer_if.sv
// Bus bundle between the fragmenter, the AXI address channel and the datapath.
// master = the issuer itself, slave = its surroundings.
interface axi_txn_issuer_if #(
  parameter int VLSU_ADDR_BITS = 32,
  parameter int AXI4_ADDR_BITS = 32,
  parameter int REQ_ID_BITS    = 8,
  parameter int TXN_BITS       = 8,
  parameter int MAX_OUTSTD     = 8
) ();

  logic                      meta_valid_i;
  logic                      meta_ready_o;
  logic [REQ_ID_BITS-1:0]    meta_req_id_i;
  logic                      meta_is_load_i;
  logic [VLSU_ADDR_BITS-1:0] meta_seg_base_i;
  logic [TXN_BITS-1:0]       meta_txn_cnt_i;
  logic [TXN_BITS-1:0]       meta_txn_num_i;
  logic [5:0]                meta_ltn_i;
  logic                      meta_final_i;

  logic                      ax_valid_o;
  logic                      ax_ready_i;
  logic [AXI4_ADDR_BITS-1:0] ax_addr_o;
  logic                      ax_is_load_o;
  logic [REQ_ID_BITS-1:0]    ax_id_o;

  logic                      info_valid_o;
  logic                      info_ready_i;
  logic [4:0]                info_start_nb_o;
  logic [5:0]                info_end_nb_o;
  logic                      info_is_load_o;
  logic                      info_last_o;

  logic                                  resp_done_i;
  logic [$clog2(MAX_OUTSTD+1)-1:0]       outstd_cnt_o;
  logic                                  idle_o;

  modport master (
    input  meta_valid_i, meta_req_id_i, meta_is_load_i, meta_seg_base_i,
           meta_txn_cnt_i, meta_txn_num_i, meta_ltn_i, meta_final_i,
           ax_ready_i, info_ready_i, resp_done_i,
    output meta_ready_o, ax_valid_o, ax_addr_o, ax_is_load_o, ax_id_o,
           info_valid_o, info_start_nb_o, info_end_nb_o, info_is_load_o,
           info_last_o, outstd_cnt_o, idle_o
  );

  modport slave (
    output meta_valid_i, meta_req_id_i, meta_is_load_i, meta_seg_base_i,
           meta_txn_cnt_i, meta_txn_num_i, meta_ltn_i, meta_final_i,
           ax_ready_i, info_ready_i, resp_done_i,
    input  meta_ready_o, ax_valid_o, ax_addr_o, ax_is_load_o, ax_id_o,
           info_valid_o, info_start_nb_o, info_end_nb_o, info_is_load_o,
           info_last_o, outstd_cnt_o, idle_o
  );

endinterface

// File: rtl/axi_txn_issuer_txn_addr_calc.sv
// Combinational nibble-to-byte address and start/end nibble computation for
// one transaction of a segment.
module txn_addr_calc
  import axi_txn_issuer_pkg::*;
#(
  parameter int VLSU_ADDR_BITS = 32,
  parameter int AXI4_ADDR_BITS = 32,
  parameter int TXN_BITS       = 8
) (
  input  logic [VLSU_ADDR_BITS-1:0] i_seg_base,
  input  logic [TXN_BITS-1:0]       i_txn_cnt,
  input  logic [TXN_BITS-1:0]       i_txn_num,
  input  logic [5:0]                i_ltn,
  output logic [AXI4_ADDR_BITS-1:0] o_ax_addr,
  output logic [4:0]                o_start_nb,
  output logic [5:0]                o_end_nb
);

  logic [VLSU_ADDR_BITS-1:0] w_aligned;
  logic [VLSU_ADDR_BITS-1:0] w_nib;
  logic [VLSU_ADDR_BITS-1:0] w_byte;

  // Each transaction covers 32 nibbles (16 bytes) past the aligned segment base.
  assign w_aligned = {i_seg_base[VLSU_ADDR_BITS-1:5], 5'b0};
  assign w_nib     = w_aligned + (VLSU_ADDR_BITS'(i_txn_cnt) << 5);
  assign w_byte    = w_nib >> 1;
  assign o_ax_addr = AXI4_ADDR_BITS'(w_byte) & ~AXI4_ADDR_BITS'(4'hF);

  assign o_start_nb = (i_txn_cnt == '0) ? i_seg_base[4:0] : 5'd0;
  assign o_end_nb   = txn_end_nb(i_txn_cnt == i_txn_num, i_ltn);

endmodule

// File: rtl/axi_txn_issuer.sv
// Single-slot AXI address/info issuer with outstanding-transaction throttling.
// Define AXI_TXN_ISSUER_PERF_CNT_EN to build the handshake/stall perf counters.
module axi_txn_issuer
  import axi_txn_issuer_pkg::*;
#(
  parameter int VLSU_ADDR_BITS = 32,
  parameter int AXI4_ADDR_BITS = 32,
  parameter int REQ_ID_BITS    = 8,
  parameter int TXN_BITS       = 8,
  parameter int MAX_OUTSTD     = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  axi_txn_issuer_if.master    io,
  output logic [31:0]         perf_txn_o,
  output logic [31:0]         perf_stall_o
);

  localparam int CNT_W  = $clog2(MAX_OUTSTD + 1);
  localparam int CNT_XW = CNT_W + 1;

  slot_state_e               r_state;
  slot_state_e               w_state_nxt;
  logic [AXI4_ADDR_BITS-1:0] r_ax_addr;
  logic                      r_ax_is_load;
  logic [REQ_ID_BITS-1:0]    r_ax_id;
  txn_info_t                 r_info;
  logic [CNT_W-1:0]          r_outstd;
  logic [CNT_W-1:0]          w_outstd_nxt;

  logic [AXI4_ADDR_BITS-1:0] w_calc_addr;
  logic [4:0]                w_calc_start;
  logic [5:0]                w_calc_end;

  logic                      w_ax_valid;
  logic                      w_info_valid;
  logic                      w_ax_hs;
  logic                      w_info_hs;
  logic                      w_slot_frees;
  logic                      w_resp_eff;
  logic [CNT_XW-1:0]         w_cnt_after;
  logic                      w_meta_ready;
  logic                      w_meta_fire;

  txn_addr_calc #(
    .VLSU_ADDR_BITS (VLSU_ADDR_BITS),
    .AXI4_ADDR_BITS (AXI4_ADDR_BITS),
    .TXN_BITS       (TXN_BITS)
  ) u_txn_addr_calc (
    .i_seg_base (io.meta_seg_base_i),
    .i_txn_cnt  (io.meta_txn_cnt_i),
    .i_txn_num  (io.meta_txn_num_i),
    .i_ltn      (io.meta_ltn_i),
    .o_ax_addr  (w_calc_addr),
    .o_start_nb (w_calc_start),
    .o_end_nb   (w_calc_end)
  );

  // Valids decode from registered state only, never from the matching ready.
  assign w_ax_valid   = (r_state == S_PEND) || (r_state == S_AX_ONLY);
  assign w_info_valid = (r_state == S_PEND) || (r_state == S_INFO_ONLY);
  assign w_ax_hs      = w_ax_valid && io.ax_ready_i;
  assign w_info_hs    = w_info_valid && io.info_ready_i;

  // The slot is reusable next cycle once every still-unsent record leaves now.
  assign w_slot_frees = (!w_ax_valid || io.ax_ready_i) && (!w_info_valid || io.info_ready_i);
  assign w_resp_eff   = io.resp_done_i && (r_outstd != '0);
  assign w_cnt_after  = CNT_XW'(r_outstd) + CNT_XW'(w_ax_hs) - CNT_XW'(w_resp_eff);
  assign w_meta_ready = w_slot_frees && (w_cnt_after < CNT_XW'(MAX_OUTSTD));
  assign w_meta_fire  = io.meta_valid_i && w_meta_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: w_state_nxt = S_EMPTY;
      S_PEND: begin
        if (w_ax_hs && w_info_hs) w_state_nxt = S_EMPTY;
        else if (w_ax_hs)         w_state_nxt = S_INFO_ONLY;
        else if (w_info_hs)       w_state_nxt = S_AX_ONLY;
      end
      S_AX_ONLY:   if (w_ax_hs)   w_state_nxt = S_EMPTY;
      S_INFO_ONLY: if (w_info_hs) w_state_nxt = S_EMPTY;
      default:     w_state_nxt = S_EMPTY;
    endcase
    if (w_meta_fire) w_state_nxt = S_PEND;
  end

  always_comb begin
    w_outstd_nxt = r_outstd;
    if (w_ax_hs && !w_resp_eff && (r_outstd != CNT_W'(MAX_OUTSTD))) begin
      w_outstd_nxt = r_outstd + CNT_W'(1);
    end else if (!w_ax_hs && w_resp_eff) begin
      w_outstd_nxt = r_outstd - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the statements appear in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_EMPTY;
      r_outstd <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_outstd <= w_outstd_nxt;
    end
  end

  // NOTE: the slot payload has no reset; it is only observed while a valid,
  // which is reset, is high, so resetting it would only cost flop area.
  always_ff @(posedge clk_i) begin
    if (w_meta_fire) begin
      r_ax_addr       <= w_calc_addr;
      r_ax_is_load    <= io.meta_is_load_i;
      r_ax_id         <= io.meta_req_id_i;
      r_info.start_nb <= w_calc_start;
      r_info.end_nb   <= w_calc_end;
      r_info.is_load  <= io.meta_is_load_i;
      r_info.last     <= io.meta_final_i;
    end
  end

  assign io.meta_ready_o    = w_meta_ready;
  assign io.ax_valid_o      = w_ax_valid;
  assign io.ax_addr_o       = r_ax_addr;
  assign io.ax_is_load_o    = r_ax_is_load;
  assign io.ax_id_o         = r_ax_id;
  assign io.info_valid_o    = w_info_valid;
  assign io.info_start_nb_o = r_info.start_nb;
  assign io.info_end_nb_o   = r_info.end_nb;
  assign io.info_is_load_o  = r_info.is_load;
  assign io.info_last_o     = r_info.last;
  assign io.outstd_cnt_o    = r_outstd;
  assign io.idle_o          = (r_state == S_EMPTY) && (r_outstd == '0);

`ifdef AXI_TXN_ISSUER_PERF_CNT_EN
  logic [31:0] r_perf_txn;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_txn   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_ax_hs)                           r_perf_txn   <= r_perf_txn + 32'd1;
      if (io.meta_valid_i && !w_meta_ready)  r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_txn_o   = r_perf_txn;
  assign perf_stall_o = r_perf_stall;
`else
  assign perf_txn_o   = '0;
  assign perf_stall_o = '0;
`endif

  a_ax_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_ax_valid && !io.ax_ready_i) |=> (w_ax_valid && $stable(r_ax_addr) && $stable(r_ax_id)));

  a_info_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_info_valid && !io.info_ready_i) |=> (w_info_valid && $stable(r_info)));

  a_outstd_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_outstd <= CNT_W'(MAX_OUTSTD));

endmodule

// File: tb/tb_axi_txn_issuer.sv
// Self-checking bench: directed scenarios plus a randomized run scored against
// a queue-based transaction model.
module tb_axi_txn_issuer;
  import axi_txn_issuer_pkg::*;

  localparam int MAX1 = 8;
  localparam int MAX2 = 2;

  logic        clk_i  = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] perf_txn1, perf_stall1, perf_txn2, perf_stall2;
  int          total = 0;
  int          bad   = 0;

  always #5 clk_i = ~clk_i;

  axi_txn_issuer_if #(.MAX_OUTSTD(MAX1)) bus1 ();
  axi_txn_issuer_if #(.MAX_OUTSTD(MAX2)) bus2 ();

  axi_txn_issuer #(.MAX_OUTSTD(MAX1)) u_dut (
    .clk_i (clk_i), .rst_ni (rst_ni), .io (bus1),
    .perf_txn_o (perf_txn1), .perf_stall_o (perf_stall1)
  );

  axi_txn_issuer #(.MAX_OUTSTD(MAX2)) u_dut2 (
    .clk_i (clk_i), .rst_ni (rst_ni), .io (bus2),
    .perf_txn_o (perf_txn2), .perf_stall_o (perf_stall2)
  );

  typedef struct {
    logic [31:0] addr;
    logic        is_load;
    logic [7:0]  id;
  } ax_rec_t;

  typedef struct {
    logic [4:0] start_nb;
    logic [5:0] end_nb;
    logic       is_load;
    logic       last;
  } info_rec_t;

  function automatic ax_rec_t model_ax(logic [31:0] base, logic [7:0] cnt, logic [7:0] id, logic ld);
    ax_rec_t     r;
    logic [31:0] nib;
    nib       = (base - (base % 32)) + 32'(cnt) * 32;
    r.addr    = nib / 2;
    r.is_load = ld;
    r.id      = id;
    return r;
  endfunction

  function automatic info_rec_t model_info(logic [31:0] base, logic [7:0] cnt, logic [7:0] num,
                                           logic [5:0] ltn, logic ld, logic fin);
    info_rec_t r;
    r.start_nb = (cnt == 0) ? base[4:0] : 5'd0;
    r.end_nb   = (cnt == num) ? ltn : 6'd32;
    r.is_load  = ld;
    r.last     = fin;
    return r;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_inputs();
    bus1.meta_valid_i = 0; bus1.meta_req_id_i = '0; bus1.meta_is_load_i = 0;
    bus1.meta_seg_base_i = '0; bus1.meta_txn_cnt_i = '0; bus1.meta_txn_num_i = '0;
    bus1.meta_ltn_i = '0; bus1.meta_final_i = 0;
    bus1.ax_ready_i = 0; bus1.info_ready_i = 0; bus1.resp_done_i = 0;
    bus2.meta_valid_i = 0; bus2.meta_req_id_i = '0; bus2.meta_is_load_i = 0;
    bus2.meta_seg_base_i = '0; bus2.meta_txn_cnt_i = '0; bus2.meta_txn_num_i = '0;
    bus2.meta_ltn_i = '0; bus2.meta_final_i = 0;
    bus2.ax_ready_i = 0; bus2.info_ready_i = 0; bus2.resp_done_i = 0;
  endtask

  task automatic set_meta1(logic [31:0] base, logic [7:0] cnt, logic [7:0] num, logic [5:0] ltn,
                           logic ld, logic [7:0] id, logic fin);
    bus1.meta_seg_base_i = base; bus1.meta_txn_cnt_i = cnt; bus1.meta_txn_num_i = num;
    bus1.meta_ltn_i = ltn; bus1.meta_is_load_i = ld; bus1.meta_req_id_i = id;
    bus1.meta_final_i = fin; bus1.meta_valid_i = 1;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst_ni = 0;
    repeat (2) @(negedge clk_i);
    total++; if (bus1.ax_valid_o !== 1'b0) begin bad++; $display("FAIL rst_ax_valid: got %b want 0", bus1.ax_valid_o); end
    total++; if (bus1.info_valid_o !== 1'b0) begin bad++; $display("FAIL rst_info_valid: got %b want 0", bus1.info_valid_o); end
    total++; if (bus1.outstd_cnt_o !== 4'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", bus1.outstd_cnt_o); end
    total++; if (bus1.meta_ready_o !== 1'b1) begin bad++; $display("FAIL rst_meta_ready: got %b want 1", bus1.meta_ready_o); end
    total++; if (bus1.idle_o !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", bus1.idle_o); end
    total++; if (bus2.idle_o !== 1'b1 || bus2.meta_ready_o !== 1'b1) begin
      bad++; $display("FAIL rst_dut2: idle=%b ready=%b want 1 1", bus2.idle_o, bus2.meta_ready_o); end
    step();
    rst_ni = 1;
    step();
  endtask

  task automatic test_addr_calc();
    set_meta1(32'h105, 8'd0, 8'd1, 6'd5, 1'b1, 8'h3C, 1'b0);
    @(negedge clk_i);
    total++; if (bus1.meta_ready_o !== 1'b1) begin bad++; $display("FAIL addr_meta_ready_empty: got %b want 1", bus1.meta_ready_o); end
    step();
    set_meta1(32'h105, 8'd1, 8'd1, 6'd5, 1'b1, 8'h3C, 1'b1);
    @(negedge clk_i);
    total++; if (bus1.ax_valid_o !== 1'b1 || bus1.info_valid_o !== 1'b1) begin
      bad++; $display("FAIL t0_valids: ax=%b info=%b want 1 1", bus1.ax_valid_o, bus1.info_valid_o); end
    total++; if (bus1.ax_addr_o !== 32'h80) begin bad++; $display("FAIL t0_addr: got %h want 80", bus1.ax_addr_o); end
    total++; if (bus1.info_start_nb_o !== 5'd5) begin bad++; $display("FAIL t0_start: got %0d want 5", bus1.info_start_nb_o); end
    total++; if (bus1.info_end_nb_o !== 6'd32) begin bad++; $display("FAIL t0_end: got %0d want 32", bus1.info_end_nb_o); end
    total++; if (bus1.ax_is_load_o !== 1'b1 || bus1.info_is_load_o !== 1'b1) begin
      bad++; $display("FAIL t0_is_load: ax=%b info=%b want 1 1", bus1.ax_is_load_o, bus1.info_is_load_o); end
    total++; if (bus1.ax_id_o !== 8'h3C) begin bad++; $display("FAIL t0_id: got %h want 3c", bus1.ax_id_o); end
    total++; if (bus1.info_last_o !== 1'b0) begin bad++; $display("FAIL t0_last: got %b want 0", bus1.info_last_o); end
    total++; if (bus1.meta_ready_o !== 1'b0) begin bad++; $display("FAIL t0_busy_ready: got %b want 0", bus1.meta_ready_o); end
    bus1.ax_ready_i = 1; bus1.info_ready_i = 1;
    #1;
    total++; if (bus1.meta_ready_o !== 1'b1) begin bad++; $display("FAIL t0_free_ready: got %b want 1", bus1.meta_ready_o); end
    step();
    bus1.ax_ready_i = 0; bus1.info_ready_i = 0; bus1.meta_valid_i = 0;
    @(negedge clk_i);
    total++; if (bus1.ax_addr_o !== 32'h90) begin bad++; $display("FAIL t1_addr: got %h want 90", bus1.ax_addr_o); end
    total++; if (bus1.info_start_nb_o !== 5'd0) begin bad++; $display("FAIL t1_start: got %0d want 0", bus1.info_start_nb_o); end
    total++; if (bus1.info_end_nb_o !== 6'd5) begin bad++; $display("FAIL t1_end: got %0d want 5", bus1.info_end_nb_o); end
    total++; if (bus1.info_last_o !== 1'b1) begin bad++; $display("FAIL t1_last: got %b want 1", bus1.info_last_o); end
    total++; if (bus1.outstd_cnt_o !== 4'd1) begin bad++; $display("FAIL t1_cnt: got %0d want 1", bus1.outstd_cnt_o); end
    bus1.ax_ready_i = 1; bus1.info_ready_i = 1;
    step();
    bus1.ax_ready_i = 0; bus1.info_ready_i = 0; bus1.resp_done_i = 1;
    @(negedge clk_i);
    total++; if (bus1.outstd_cnt_o !== 4'd2 || bus1.idle_o !== 1'b0 || bus1.ax_valid_o !== 1'b0) begin
      bad++; $display("FAIL t1_drained: cnt=%0d idle=%b axv=%b want 2 0 0", bus1.outstd_cnt_o, bus1.idle_o, bus1.ax_valid_o); end
    step();
    step();
    bus1.resp_done_i = 0;
    @(negedge clk_i);
    total++; if (bus1.outstd_cnt_o !== 4'd0 || bus1.idle_o !== 1'b1) begin
      bad++; $display("FAIL addr_final_idle: cnt=%0d idle=%b want 0 1", bus1.outstd_cnt_o, bus1.idle_o); end
    step();
  endtask

  task automatic test_info_stall();
    set_meta1(32'h2000_0040, 8'd2, 8'd3, 6'd7, 1'b0, 8'h11, 1'b0);
    bus1.ax_ready_i = 1; bus1.info_ready_i = 0;
    step();
    bus1.meta_valid_i = 0;
    repeat (3) step();
    @(negedge clk_i);
    total++; if (bus1.ax_valid_o !== 1'b0 || bus1.info_valid_o !== 1'b1) begin
      bad++; $display("FAIL stall_state: axv=%b infov=%b want 0 1", bus1.ax_valid_o, bus1.info_valid_o); end
    total++; if (bus1.meta_ready_o !== 1'b0) begin bad++; $display("FAIL stall_meta_ready: got %b want 0", bus1.meta_ready_o); end
    total++; if (bus1.outstd_cnt_o !== 4'd1) begin bad++; $display("FAIL stall_cnt: got %0d want 1", bus1.outstd_cnt_o); end
    total++; if (bus1.info_start_nb_o !== 5'd0 || bus1.info_end_nb_o !== 6'd32 || bus1.info_is_load_o !== 1'b0) begin
      bad++; $display("FAIL stall_info: start=%0d end=%0d ld=%b want 0 32 0",
                      bus1.info_start_nb_o, bus1.info_end_nb_o, bus1.info_is_load_o); end
    bus1.info_ready_i = 1;
    step();
    bus1.info_ready_i = 0; bus1.ax_ready_i = 0; bus1.resp_done_i = 1;
    step();
    bus1.resp_done_i = 0;
    @(negedge clk_i);
    total++; if (bus1.idle_o !== 1'b1) begin bad++; $display("FAIL stall_idle: got %b want 1", bus1.idle_o); end
    step();
  endtask

  task automatic test_outstd_limit();
    bus2.meta_seg_base_i = 32'h40; bus2.meta_ltn_i = 6'd32; bus2.meta_valid_i = 1;
    bus2.ax_ready_i = 1; bus2.info_ready_i = 1;
    step();
    step();
    @(negedge clk_i);
    total++; if (bus2.meta_ready_o !== 1'b0) begin bad++; $display("FAIL lim_ready_at_edge: got %b want 0", bus2.meta_ready_o); end
    step();
    bus2.meta_valid_i = 0;
    @(negedge clk_i);
    total++; if (bus2.meta_ready_o !== 1'b0 || bus2.outstd_cnt_o !== 2'd2) begin
      bad++; $display("FAIL lim_full: ready=%b cnt=%0d want 0 2", bus2.meta_ready_o, bus2.outstd_cnt_o); end
    bus2.resp_done_i = 1;
    #1;
    total++; if (bus2.meta_ready_o !== 1'b1) begin bad++; $display("FAIL lim_resp_ready: got %b want 1", bus2.meta_ready_o); end
    step();
    step();
    bus2.resp_done_i = 0;
    @(negedge clk_i);
    total++; if (bus2.outstd_cnt_o !== 2'd0 || bus2.idle_o !== 1'b1) begin
      bad++; $display("FAIL lim_drain: cnt=%0d idle=%b want 0 1", bus2.outstd_cnt_o, bus2.idle_o); end
    clr_inputs();
    step();
  endtask

  task automatic test_cnt_coincident();
    set_meta1(32'h300, 8'd0, 8'd0, 6'd16, 1'b0, 8'h22, 1'b1);
    bus1.ax_ready_i = 1; bus1.info_ready_i = 1;
    step();
    step();
    step();
    bus1.meta_valid_i = 0;
    step();
    @(negedge clk_i);
    total++; if (bus1.outstd_cnt_o !== 4'd3) begin bad++; $display("FAIL coin_cnt3: got %0d want 3", bus1.outstd_cnt_o); end
    bus1.meta_valid_i = 1; bus1.ax_ready_i = 0; bus1.info_ready_i = 0;
    step();
    bus1.meta_valid_i = 0; bus1.ax_ready_i = 1; bus1.info_ready_i = 1; bus1.resp_done_i = 1;
    @(negedge clk_i);
    total++; if (bus1.ax_valid_o !== 1'b1) begin bad++; $display("FAIL coin_pending: got %b want 1", bus1.ax_valid_o); end
    step();
    bus1.ax_ready_i = 0; bus1.info_ready_i = 0; bus1.resp_done_i = 0;
    @(negedge clk_i);
    total++; if (bus1.outstd_cnt_o !== 4'd3 || bus1.ax_valid_o !== 1'b0) begin
      bad++; $display("FAIL coin_hold: cnt=%0d axv=%b want 3 0", bus1.outstd_cnt_o, bus1.ax_valid_o); end
    bus1.resp_done_i = 1;
    repeat (4) step();
    bus1.resp_done_i = 0;
    @(negedge clk_i);
    total++; if (bus1.outstd_cnt_o !== 4'd0 || bus1.idle_o !== 1'b1) begin
      bad++; $display("FAIL coin_floor: cnt=%0d idle=%b want 0 1", bus1.outstd_cnt_o, bus1.idle_o); end
    step();
  endtask

  task automatic test_reset_mid();
    set_meta1(32'h777, 8'd0, 8'd2, 6'd9, 1'b1, 8'h5A, 1'b0);
    step();
    bus1.meta_valid_i = 0;
    @(negedge clk_i);
    total++; if (bus1.ax_valid_o !== 1'b1 || bus1.info_valid_o !== 1'b1) begin
      bad++; $display("FAIL mid_pending: axv=%b infov=%b want 1 1", bus1.ax_valid_o, bus1.info_valid_o); end
    #2 rst_ni = 0;
    #1;
    total++; if (bus1.ax_valid_o !== 1'b0 || bus1.info_valid_o !== 1'b0) begin
      bad++; $display("FAIL mid_async: axv=%b infov=%b want 0 0", bus1.ax_valid_o, bus1.info_valid_o); end
    @(negedge clk_i);
    total++; if (bus1.idle_o !== 1'b1 || bus1.meta_ready_o !== 1'b1) begin
      bad++; $display("FAIL mid_idle: idle=%b ready=%b want 1 1", bus1.idle_o, bus1.meta_ready_o); end
    step();
    rst_ni = 1;
    bus1.ax_ready_i = 1; bus1.info_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      total++; if (bus1.ax_valid_o !== 1'b0 || bus1.info_valid_o !== 1'b0) begin
        bad++; $display("FAIL mid_no_issue: cyc=%0d axv=%b infov=%b want 0 0", i, bus1.ax_valid_o, bus1.info_valid_o); end
    end
    total++; if (bus1.outstd_cnt_o !== 4'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", bus1.outstd_cnt_o); end
    clr_inputs();
    step();
  endtask

  task automatic test_random();
    ax_rec_t     exp_ax[$];
    info_rec_t   exp_info[$];
    ax_rec_t     ea;
    info_rec_t   ei;
    int          model_cnt = 0;
    int          next_cnt;
    int          n_ax = 0;
    int          num;
    logic        took = 0;
    logic        drain;
    logic        axv, infov, ax_f, info_f, resp_eff, frees, exp_ready;
    logic [31:0] perf0;
    logic [31:0] exp_perf;
    step();
    perf0 = perf_txn1;
    for (int cyc = 0; cyc < 2400; cyc++) begin
      drain = (cyc >= 2000);
      if (!bus1.meta_valid_i || took) begin
        num = $urandom_range(0, 3);
        bus1.meta_valid_i    = !drain && ($urandom_range(0, 9) < 7);
        bus1.meta_seg_base_i = $urandom();
        bus1.meta_txn_num_i  = 8'(num);
        bus1.meta_txn_cnt_i  = 8'($urandom_range(0, num));
        bus1.meta_ltn_i      = 6'($urandom_range(1, 32));
        bus1.meta_req_id_i   = 8'($urandom());
        bus1.meta_is_load_i  = 1'($urandom());
        bus1.meta_final_i    = 1'($urandom());
      end
      bus1.ax_ready_i   = drain || ($urandom_range(0, 9) < 6);
      bus1.info_ready_i = drain || ($urandom_range(0, 9) < 6);
      bus1.resp_done_i  = drain || ($urandom_range(0, 9) < 4);
      @(negedge clk_i);
      axv   = (exp_ax.size() > 0);
      infov = (exp_info.size() > 0);
      total++; if (bus1.ax_valid_o !== axv || bus1.info_valid_o !== infov) begin
        bad++; $display("FAIL rnd_valids: cyc=%0d axv=%b infov=%b want %b %b", cyc, bus1.ax_valid_o, bus1.info_valid_o, axv, infov); end
      total++; if (bus1.outstd_cnt_o !== 4'(model_cnt)) begin
        bad++; $display("FAIL rnd_cnt: cyc=%0d got %0d want %0d", cyc, bus1.outstd_cnt_o, model_cnt); end
      total++; if (bus1.idle_o !== (!axv && !infov && model_cnt == 0)) begin
        bad++; $display("FAIL rnd_idle: cyc=%0d got %b", cyc, bus1.idle_o); end
      ax_f   = axv && bus1.ax_ready_i;
      info_f = infov && bus1.info_ready_i;
      if (ax_f) begin
        ea = exp_ax.pop_front();
        n_ax++;
        total++; if (bus1.ax_addr_o !== ea.addr || bus1.ax_id_o !== ea.id || bus1.ax_is_load_o !== ea.is_load) begin
          bad++; $display("FAIL rnd_ax: cyc=%0d addr=%h id=%h ld=%b want %h %h %b", cyc,
                          bus1.ax_addr_o, bus1.ax_id_o, bus1.ax_is_load_o, ea.addr, ea.id, ea.is_load); end
      end
      if (info_f) begin
        ei = exp_info.pop_front();
        total++; if (bus1.info_start_nb_o !== ei.start_nb || bus1.info_end_nb_o !== ei.end_nb ||
                     bus1.info_is_load_o !== ei.is_load || bus1.info_last_o !== ei.last) begin
          bad++; $display("FAIL rnd_info: cyc=%0d start=%0d end=%0d ld=%b last=%b want %0d %0d %b %b", cyc,
                          bus1.info_start_nb_o, bus1.info_end_nb_o, bus1.info_is_load_o, bus1.info_last_o,
                          ei.start_nb, ei.end_nb, ei.is_load, ei.last); end
      end
      resp_eff  = bus1.resp_done_i && (model_cnt > 0);
      next_cnt  = model_cnt + int'(ax_f) - int'(resp_eff);
      frees     = (!axv || bus1.ax_ready_i) && (!infov || bus1.info_ready_i);
      exp_ready = frees && (next_cnt < MAX1);
      total++; if (bus1.meta_ready_o !== exp_ready) begin
        bad++; $display("FAIL rnd_meta_ready: cyc=%0d got %b want %b", cyc, bus1.meta_ready_o, exp_ready); end
      took = bus1.meta_valid_i && exp_ready;
      if (took) begin
        exp_ax.push_back(model_ax(bus1.meta_seg_base_i, bus1.meta_txn_cnt_i, bus1.meta_req_id_i, bus1.meta_is_load_i));
        exp_info.push_back(model_info(bus1.meta_seg_base_i, bus1.meta_txn_cnt_i, bus1.meta_txn_num_i,
                                      bus1.meta_ltn_i, bus1.meta_is_load_i, bus1.meta_final_i));
      end
      model_cnt = next_cnt;
      @(posedge clk_i);
      #1;
    end
    @(negedge clk_i);
    total++; if (exp_ax.size() != 0 || exp_info.size() != 0 || bus1.idle_o !== 1'b1) begin
      bad++; $display("FAIL rnd_drain: ax_left=%0d info_left=%0d idle=%b want 0 0 1", exp_ax.size(), exp_info.size(), bus1.idle_o); end
`ifdef AXI_TXN_ISSUER_PERF_CNT_EN
    exp_perf = perf0 + 32'(n_ax);
`else
    exp_perf = 32'd0;
`endif
    total++; if (perf_txn1 !== exp_perf) begin
      bad++; $display("FAIL rnd_perf_txn: got %0d want %0d", perf_txn1, exp_perf); end
    clr_inputs();
  endtask

  initial begin
    test_reset();
    test_addr_calc();
    test_info_stall();
    test_outstd_limit();
    test_cnt_coincident();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
